// File: rtl/conv_mac_5x5_if.sv
// conv_mac_5x5_if
//   Stream and weight-load signals of the 5x5 convolution MAC.
//   master : producer side (drives window, weight words; observes results)
//   slave  : conv_mac_5x5 side
// Signals
//   in_val    window valid, one window per cycle, no backpressure
//   data_in   flattened window, element k = row*FILTER_SIZE+col at [k*DATA_BITS +: DATA_BITS]
//   w_val     weight word strobe
//   w_first   with w_val: word is tap 0, restarts the load
//   w_data    signed weight/bias word (taps 0..N-1, then bias)
//   data_out  result pixel
//   valid     one-cycle pulse per result
//   w_ready   an active kernel is loaded
interface conv_mac_5x5_if #(
  parameter int DATA_BITS   = 8,
  parameter int FILTER_SIZE = 5,
  parameter int WEIGHT_BITS = 8,
  parameter int OUT_BITS    = 8
);
  localparam int N = FILTER_SIZE * FILTER_SIZE;

  logic                     in_val;
  logic [N*DATA_BITS-1:0]   data_in;
  logic                     w_val;
  logic                     w_first;
  logic [WEIGHT_BITS-1:0]   w_data;
  logic [OUT_BITS-1:0]      data_out;
  logic                     valid;
  logic                     w_ready;

  modport master (
    output in_val, data_in, w_val, w_first, w_data,
    input  data_out, valid, w_ready
  );

  modport slave (
    input  in_val, data_in, w_val, w_first, w_data,
    output data_out, valid, w_ready
  );
endinterface

// File: rtl/conv_mac_5x5.sv
// conv_mac_5x5
//   Multiplies a FILTER_SIZE x FILTER_SIZE unsigned pixel window by a signed kernel, adds a
//   bias, applies ReLU, an arithmetic right shift and unsigned saturation, and emits one
//   pixel per accepted window with a fixed latency of 4 clock edges.
//   Kernel and bias are loaded serially into a shadow bank and committed atomically to the
//   active bank on the bias word, so reloading never stalls the stream.
// Ports
//   clk  rising-edge clock
//   rst  asynchronous reset, active high
//   bus  conv_mac_5x5_if.slave (window stream, weight load, result)
module conv_mac_5x5 #(
  parameter int DATA_BITS   = 8,
  parameter int FILTER_SIZE = 5,
  parameter int WEIGHT_BITS = 8,
  parameter int OUT_BITS    = 8,
  parameter int SHIFT       = 0
) (
  input  logic           clk,
  input  logic           rst,
  conv_mac_5x5_if.slave  bus
);
  localparam int N         = FILTER_SIZE * FILTER_SIZE;
  localparam int PROD_BITS = DATA_BITS + WEIGHT_BITS + 1;
  localparam int ACC_BITS  = DATA_BITS + WEIGHT_BITS + 1 + $clog2(N) + 1;
  localparam int WC_BITS   = $clog2(N + 1);

  typedef enum logic {ST_EMPTY, ST_RUN} state_t;

  // ---------------------------------------------------------------------------
  // Weight load and bank control
  // ---------------------------------------------------------------------------
  state_t                         state;
  logic [WC_BITS-1:0]             wc;
  logic signed [WEIGHT_BITS-1:0]  shadow_w [N];
  logic signed [WEIGHT_BITS-1:0]  active_w [N];
  logic signed [WEIGHT_BITS-1:0]  active_b;
  logic                           w_ready_q;
  logic                           accept;

  // The window sampled on a commit edge still sees the old active bank,
  // because the bank update is non-blocking on that same edge.
  assign accept = bus.in_val && (state == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      wc        <= '0;
      w_ready_q <= 1'b0;
      active_b  <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        shadow_w[k] <= '0;
        active_w[k] <= '0;
      end
    end else if (bus.w_val) begin
      if (bus.w_first) begin
        shadow_w[0] <= bus.w_data;
        wc          <= WC_BITS'(1);
      end else if (wc == WC_BITS'(N)) begin
        // Bias word: commit shadow taps and this bias together.
        for (int unsigned k = 0; k < N; k++) begin
          active_w[k] <= shadow_w[k];
        end
        active_b  <= bus.w_data;
        wc        <= '0;
        state     <= ST_RUN;
        w_ready_q <= 1'b1;
      end else begin
        shadow_w[wc] <= bus.w_data;
        wc           <= wc + WC_BITS'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline valids
  // ---------------------------------------------------------------------------
  logic s1_v, s2_v, s3_v, s4_v;
  logic valid_q;
  logic [OUT_BITS-1:0] out_q;

  // ---------------------------------------------------------------------------
  // S1: element-wise products; bias travels with the window from here on
  // ---------------------------------------------------------------------------
  logic signed [PROD_BITS-1:0]   s1_p [N];
  logic signed [WEIGHT_BITS-1:0] s1_b;

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned k = 0; k < N; k++) begin
        s1_p[k] <= PROD_BITS'($signed({1'b0, bus.data_in[k*DATA_BITS +: DATA_BITS]}))
                 * PROD_BITS'(active_w[k]);
      end
      s1_b <= active_b;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: row sums
  // ---------------------------------------------------------------------------
  logic signed [ACC_BITS-1:0]    row_c  [FILTER_SIZE];
  logic signed [ACC_BITS-1:0]    s2_row [FILTER_SIZE];
  logic signed [WEIGHT_BITS-1:0] s2_b;

  always_comb begin
    for (int unsigned r = 0; r < FILTER_SIZE; r++) begin
      row_c[r] = '0;
      for (int unsigned c = 0; c < FILTER_SIZE; c++) begin
        row_c[r] = row_c[r] + ACC_BITS'(s1_p[r*FILTER_SIZE + c]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s1_v) begin
      for (int unsigned r = 0; r < FILTER_SIZE; r++) begin
        s2_row[r] <= row_c[r];
      end
      s2_b <= s1_b;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: total plus sign-extended bias
  // ---------------------------------------------------------------------------
  logic signed [ACC_BITS-1:0] acc_c;
  logic signed [ACC_BITS-1:0] s3_acc;

  always_comb begin
    acc_c = ACC_BITS'(s2_b);
    for (int unsigned r = 0; r < FILTER_SIZE; r++) begin
      acc_c = acc_c + s2_row[r];
    end
  end

  always_ff @(posedge clk) begin
    if (s2_v) begin
      s3_acc <= acc_c;
    end
  end

  // ---------------------------------------------------------------------------
  // S4: ReLU and requantising shift; saturation feeds the output register,
  // which is the fourth edge after the accepting edge.
  // ---------------------------------------------------------------------------
  logic [ACC_BITS-1:0] relu_c;
  logic [ACC_BITS-1:0] s4_r;
  logic [OUT_BITS-1:0] sat_c;

  always_comb begin
    relu_c = '0;
    if (!s3_acc[ACC_BITS-1]) begin
      relu_c = s3_acc >>> SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (s3_v) begin
      s4_r <= relu_c;
    end
  end

  always_comb begin
    sat_c = s4_r[OUT_BITS-1:0];
    if (|s4_r[ACC_BITS-1:OUT_BITS]) begin
      sat_c = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s3_v    <= 1'b0;
      s4_v    <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      s1_v    <= accept;
      s2_v    <= s1_v;
      s3_v    <= s2_v;
      s4_v    <= s3_v;
      valid_q <= s4_v;
      if (s4_v) begin
        out_q <= sat_c;
      end
    end
  end

  assign bus.data_out = out_q;
  assign bus.valid    = valid_q;
  assign bus.w_ready  = w_ready_q;

endmodule

// File: tb/tb_conv_mac_5x5.sv
// tb_conv_mac_5x5
//   Directed stimulus for conv_mac_5x5 with a behavioural reference model (word list for the
//   kernel load, plain integer dot product for each window) and a per-cycle compare process,
//   plus literal expectations for the documented example cases.
module tb_conv_mac_5x5;
  localparam int DB = 8;
  localparam int FS = 5;
  localparam int WB = 8;
  localparam int OB = 8;
  localparam int SH = 0;
  localparam int N  = FS * FS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_mac_5x5_if #(.DATA_BITS(DB), .FILTER_SIZE(FS), .WEIGHT_BITS(WB), .OUT_BITS(OB)) bus ();

  conv_mac_5x5 #(
    .DATA_BITS(DB), .FILTER_SIZE(FS), .WEIGHT_BITS(WB), .OUT_BITS(OB), .SHIFT(SH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct { int due; int val; } exp_t;
  typedef struct { int cyc; int val; } out_t;

  exp_t exp_q[$];
  out_t outs[$];
  int   words[$];
  int   m_tap [N];
  int   m_bias   = 0;
  bit   m_loaded = 1'b0;
  int   cyc      = 0;
  int   last_out = 0;

  function automatic int model_pix(input logic [N*DB-1:0] d);
    int s;
    s = m_bias;
    for (int k = 0; k < N; k++) s += int'(d[k*DB +: DB]) * m_tap[k];
    if (s < 0) s = 0;
    s = s >>> SH;
    if (s > (1 << OB) - 1) s = (1 << OB) - 1;
    return s;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      words.delete();
      m_loaded = 1'b0;
    end else begin
      if (bus.in_val && m_loaded) exp_q.push_back('{cyc + 4, model_pix(bus.data_in)});
      if (bus.w_val) begin
        if (bus.w_first) words.delete();
        words.push_back(int'($signed(bus.w_data)));
        if (words.size() == N + 1) begin
          for (int k = 0; k < N; k++) m_tap[k] = words[k];
          m_bias   = words[N];
          m_loaded = 1'b1;
          words.delete();
        end
      end
    end
  end

  // Compare process: runs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", int'(bus.valid), 0);
      chk("rst_data_out", int'(bus.data_out), 0);
      chk("rst_w_ready", int'(bus.w_ready), 0);
      exp_q.delete();
      last_out = 0;
    end else begin
      bit exp_v;
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      if (exp_v) last_out = exp_q.pop_front().val;
      chk("valid", int'(bus.valid), int'(exp_v));
      chk("data_out", int'(bus.data_out), last_out);
      chk("w_ready", int'(bus.w_ready), int'(m_loaded));
      if (bus.valid) outs.push_back('{cyc, int'(bus.data_out)});
    end
  end

  function automatic int out_val(input int i);
    if (i < outs.size()) return outs[i].val;
    return -1;
  endfunction

  function automatic int out_cyc(input int i);
    if (i < outs.size()) return outs[i].cyc;
    return -1000;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.in_val  = 1'b0;
    bus.w_val   = 1'b0;
    bus.w_first = 1'b0;
    bus.w_data  = '0;
  endtask

  task automatic set_window(input int v);
    for (int k = 0; k < N; k++) bus.data_in[k*DB +: DB] = DB'(v);
  endtask

  task automatic load(input int tap, input int bias);
    for (int i = 0; i <= N; i++) begin
      bus.w_val   = 1'b1;
      bus.w_first = (i == 0);
      bus.w_data  = (i < N) ? WB'(tap) : WB'(bias);
      tick();
    end
    bus.w_val   = 1'b0;
    bus.w_first = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int exp5[8];
    idle();
    bus.data_in = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Windows before any kernel load are ignored.
    outs.delete();
    set_window(7);
    bus.in_val = 1'b1;
    repeat (5) tick();
    bus.in_val = 1'b0;
    repeat (6) tick();
    chk("noload_count", outs.size(), 0);
    chk("noload_w_ready", int'(bus.w_ready), 0);

    // Taps +1, bias 0, window 10 -> 250 exactly 4 edges after acceptance.
    load(1, 0);
    chk("t1_w_ready", int'(bus.w_ready), 1);
    outs.delete();
    set_window(10);
    bus.in_val = 1'b1;
    tick();
    t0 = cyc;
    bus.in_val = 1'b0;
    repeat (6) tick();
    chk("t1_count", outs.size(), 1);
    chk("t1_latency", out_cyc(0) - t0, 4);
    chk("t1_value", out_val(0), 250);

    // Saturation: window 255 -> 6375 -> 255.
    outs.delete();
    set_window(255);
    bus.in_val = 1'b1;
    tick();
    bus.in_val = 1'b0;
    repeat (6) tick();
    chk("t2_value", out_val(0), 255);

    // Taps -1, bias +5: window 1 -> -20 -> 0; window 0 -> 5.
    load(-1, 5);
    outs.delete();
    set_window(1);
    bus.in_val = 1'b1;
    tick();
    set_window(0);
    tick();
    bus.in_val = 1'b0;
    repeat (6) tick();
    chk("t3_count", outs.size(), 2);
    chk("t3_relu", out_val(0), 0);
    chk("t3_bias", out_val(1), 5);

    // Back-to-back stream k=1..6 with taps +1.
    load(1, 0);
    outs.delete();
    bus.in_val = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      set_window(k);
      tick();
    end
    bus.in_val = 1'b0;
    repeat (6) tick();
    chk("t4_count", outs.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("t4_value", out_val(i), 25 * (i + 1));
      chk("t4_spacing", out_cyc(i) - out_cyc(0), i);
    end

    // Reload taps +2 while streaming windows of 3; commit edge coincides with window i=25.
    outs.delete();
    set_window(3);
    for (int i = 0; i < 28; i++) begin
      bus.in_val  = (i >= 20);
      bus.w_val   = (i <= 25);
      bus.w_first = (i == 0);
      bus.w_data  = (i < 25) ? WB'(2) : WB'(0);
      tick();
    end
    idle();
    repeat (6) tick();
    exp5 = '{75, 75, 75, 75, 75, 75, 150, 150};
    chk("t5_count", outs.size(), 8);
    for (int i = 0; i < 8; i++) chk("t5_value", out_val(i), exp5[i]);

    // Restart mid-load: 10 words, then w_first again; 25 words are not yet a commit.
    outs.delete();
    for (int i = 0; i < 35; i++) begin
      bus.w_val   = 1'b1;
      bus.w_first = (i == 0) || (i == 10);
      bus.w_data  = WB'(1);
      tick();
    end
    idle();
    set_window(2);
    bus.in_val = 1'b1;
    tick();
    bus.in_val  = 1'b0;
    bus.w_val   = 1'b1;
    bus.w_data  = WB'(0);
    tick();
    idle();
    bus.in_val = 1'b1;
    tick();
    bus.in_val = 1'b0;
    repeat (6) tick();
    chk("t6_count", outs.size(), 2);
    chk("t6_old_bank", out_val(0), 100);
    chk("t6_new_bank", out_val(1), 50);

    // Reset with three results in flight.
    outs.delete();
    set_window(4);
    bus.in_val = 1'b1;
    repeat (3) tick();
    bus.in_val = 1'b0;
    rst = 1'b1;
    #1;
    chk("t7_rst_valid", int'(bus.valid), 0);
    chk("t7_rst_w_ready", int'(bus.w_ready), 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("t7_no_stray", outs.size(), 0);
    chk("t7_w_ready", int'(bus.w_ready), 0);

    // After reset the old kernel is unusable until a full reload.
    bus.in_val = 1'b1;
    repeat (3) tick();
    bus.in_val = 1'b0;
    repeat (6) tick();
    chk("t7_ignored", outs.size(), 0);
    load(1, 0);
    set_window(2);
    bus.in_val = 1'b1;
    tick();
    bus.in_val = 1'b0;
    repeat (6) tick();
    chk("t7_recover_count", outs.size(), 1);
    chk("t7_recover_value", out_val(0), 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
